// File: rtl/uart_tx_feed_pkg.sv
// Shared types and constants for the uart_tx byte feeder.
package uart_tx_feed_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    s_IDLE      = 2'd0,
    s_REQ       = 2'd1,
    s_WAIT_DONE = 2'd2
  } tx_feed_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular-buffer FIFO with occupancy, full/empty flags and a
// sticky overflow flag for writes dropped while full.
module uart_tx_fifo
  import uart_tx_feed_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  always_comb begin
    pop_ok     = pop && (count_q != '0);
    push_ok    = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & ~push_ok);
    count_d    = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout     = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to uart_tx using its
// DV / Active / Done handshake.
module uart_tx_feeder
  import uart_tx_feed_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [BYTE_W-1:0] i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [CW-1:0]     o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Busy
);

  tx_feed_state_t    state_q, state_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              pop;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .push    (i_Wr_DV),
    .pop     (pop),
    .din     (i_Wr_Byte),
    .dout    (fifo_dout),
    .count   (o_Count),
    .full    (o_Full),
    .empty   (fifo_empty),
    .overflow(o_Overflow)
  );

  // Done/Active are only honoured in the state that waits for them.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      s_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_byte_d = fifo_dout;
          state_d   = s_REQ;
        end
      end
      s_REQ:       if (i_Tx_Active) state_d = s_WAIT_DONE;
      s_WAIT_DONE: if (i_Tx_Done)   state_d = s_IDLE;
      default:     state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= s_IDLE;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_Tx_DV   = (state_q == s_REQ);
  assign o_Tx_Byte = tx_byte_q;
  assign o_Empty   = fifo_empty;
  assign o_Busy    = (state_q != s_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: queue-based reference model,
// scoreboard monitor on each new DV request, and a behavioural uart_tx.
module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_dv = 1'b0;
  logic [7:0]    wr_byte = 8'h00;
  logic          o_Full, o_Empty, o_Overflow, o_Tx_DV, o_Busy;
  logic [CW-1:0] o_Count;
  logic [7:0]    o_Tx_Byte;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done),
    .o_Busy     (o_Busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue plus a "transmitter owns a byte" flag.
  logic [7:0] ref_q[$];
  logic [7:0] exp_tx[$];
  bit         ref_holding = 0;
  bit         ref_acked   = 0;
  bit         ref_ovf     = 0;
  logic [7:0] ref_byte    = 8'h00;

  always @(posedge clk or posedge rst) begin
    bit do_pop;
    bit do_acc;
    if (rst) begin
      ref_q.delete();
      exp_tx.delete();
      ref_holding = 0;
      ref_acked   = 0;
      ref_ovf     = 0;
      ref_byte    = 8'h00;
    end else begin
      do_pop = !ref_holding && (ref_q.size() > 0);
      do_acc = wr_dv && ((ref_q.size() < DEPTH) || do_pop);
      if (wr_dv && !do_acc) ref_ovf = 1;
      if (do_pop) begin
        ref_byte = ref_q.pop_front();
        exp_tx.push_back(ref_byte);
        ref_holding = 1;
        ref_acked   = 0;
      end else if (ref_holding && !ref_acked && tx_active) begin
        ref_acked = 1;
      end else if (ref_holding && ref_acked && tx_done) begin
        ref_holding = 0;
      end
      if (do_acc) ref_q.push_back(wr_byte);
    end
  end

  // Per-cycle flag checks and scoreboard pop on each new request.
  bit dv_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      dv_prev = 0;
    end else begin
      chk("count",    int'(o_Count),    ref_q.size());
      chk("empty",    int'(o_Empty),    int'(ref_q.size() == 0));
      chk("full",     int'(o_Full),     int'(ref_q.size() == DEPTH));
      chk("overflow", int'(o_Overflow), int'(ref_ovf));
      chk("tx_dv",    int'(o_Tx_DV),    int'(ref_holding && !ref_acked));
      chk("busy",     int'(o_Busy),     int'(ref_holding || (ref_q.size() > 0)));
      chk("tx_byte",  int'(o_Tx_Byte),  int'(ref_byte));
      if (o_Tx_DV && !dv_prev) begin
        if (exp_tx.size() == 0) chk("sb_pending", 0, 1);
        else chk("sb_byte", int'(o_Tx_Byte), int'(exp_tx.pop_front()));
      end
      dv_prev = o_Tx_DV;
    end
  end

  // Behavioural uart_tx: Active after a delay, Done pulse after a length.
  bit         dn_hold = 0;
  bit         dn_rand = 0;
  bit         stray_req = 0;
  int         dn_dly = 3;
  int         dn_len = 4;
  int         dn_phase = 0;
  int         dn_cnt = 0;
  logic [7:0] emit_q[$];

  always @(negedge clk) begin
    if (rst) begin
      dn_phase  = 0;
      tx_active = 1'b0;
      tx_done   = 1'b0;
      stray_req = 0;
    end else begin
      tx_done = 1'b0;
      case (dn_phase)
        0: if (o_Tx_DV && !dn_hold) begin
          dn_cnt   = dn_rand ? int'($urandom_range(1, 3)) : dn_dly;
          dn_phase = 1;
        end
        1: begin
          if (stray_req) begin
            tx_done   = 1'b1;
            stray_req = 0;
          end
          dn_cnt--;
          if (dn_cnt == 0) begin
            tx_active = 1'b1;
            emit_q.push_back(o_Tx_Byte);
            dn_cnt   = dn_rand ? int'($urandom_range(1, 4)) : dn_len;
            dn_phase = 2;
          end
        end
        2: begin
          dn_cnt--;
          if (dn_cnt == 0) begin
            tx_active = 1'b0;
            tx_done   = 1'b1;
            dn_phase  = 3;
          end
        end
        default: dn_phase = 0;
      endcase
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr_dv   = 1'b1;
    wr_byte = b;
    @(negedge clk);
    wr_dv   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int  n = 0;
    bit  drained = 0;
    while (n < budget && !drained) begin
      @(negedge clk);
      n++;
      drained = (ref_q.size() == 0) && !ref_holding && (dn_phase == 0);
    end
    chk("drain_done", int'(drained), 1);
  endtask

  task automatic chk_emitted(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, emit_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < emit_q.size(); i++)
      chk(name, int'(emit_q[i]), int'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_l[$];
    int         pushes;
    int         guard;
    logic [7:0] nxt;
    bit         last_push;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", int'(o_Count), 0);
    chk("rst_empty", int'(o_Empty), 1);
    chk("rst_full",  int'(o_Full), 0);
    chk("rst_dv",    int'(o_Tx_DV), 0);
    chk("rst_byte",  int'(o_Tx_Byte), 0);
    chk("rst_busy",  int'(o_Busy), 0);
    chk("rst_ovf",   int'(o_Overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: request two clocks after the write
    dn_rand = 0; dn_dly = 3; dn_len = 4;
    emit_q.delete();
    write_byte(8'hA5);
    chk("t1_count_after_E", int'(o_Count), 1);
    chk("t1_dv_after_E",    int'(o_Tx_DV), 0);
    @(negedge clk);
    chk("t1_dv_after_E1",   int'(o_Tx_DV), 1);
    chk("t1_byte",          int'(o_Tx_Byte), 8'hA5);
    wait_drain(100);
    chk("t1_busy_idle", int'(o_Busy), 0);
    chk("t1_dv_idle",   int'(o_Tx_DV), 0);
    exp_l = '{8'hA5};
    chk_emitted("t1_emit", exp_l);

    // Burst 01..08 on consecutive cycles
    dn_rand = 1;
    emit_q.delete();
    exp_l.delete();
    for (int i = 1; i <= 8; i++) begin
      wr_dv = 1'b1;
      wr_byte = 8'(i);
      exp_l.push_back(8'(i));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    chk("t2_full_after_8", int'(o_Full), 0);
    wait_drain(2000);
    chk_emitted("t2_emit", exp_l);

    // Full FIFO with writes landing exactly on pop cycles, 3 pointer laps
    dn_rand = 0; dn_dly = 1; dn_len = 2; dn_hold = 1;
    emit_q.delete();
    exp_l.delete();
    for (int i = 0; i < 9; i++) begin
      wr_dv = 1'b1;
      wr_byte = 8'h10 + 8'(i);
      exp_l.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    chk("t3_count_full", int'(o_Count), DEPTH);
    dn_hold = 0;
    pushes = 0; guard = 0; nxt = 8'h20; last_push = 0;
    while (pushes < 24 && guard < 2000) begin
      if (!ref_holding && ref_q.size() > 0) begin
        wr_dv = 1'b1; wr_byte = nxt; exp_l.push_back(nxt);
        nxt++; pushes++; last_push = 1;
      end else begin
        wr_dv = 1'b0; last_push = 0;
      end
      @(negedge clk);
      guard++;
      if (last_push) begin
        chk("t3_count_hold", int'(o_Count), DEPTH);
        chk("t3_no_ovf", int'(o_Overflow), 0);
      end
    end
    wr_dv = 1'b0;
    chk("t3_pushes", pushes, 24);
    wait_drain(2000);
    chk_emitted("t3_emit", exp_l);

    // Stray Done while requesting
    dn_dly = 5; dn_len = 2;
    emit_q.delete();
    stray_req = 1;
    write_byte(8'h5A);
    write_byte(8'h5B);
    guard = 0;
    while (stray_req && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    chk("t4_stray_fired", int'(stray_req), 0);
    @(negedge clk);
    chk("t4_dv_kept",    int'(o_Tx_DV), 1);
    chk("t4_count_kept", int'(o_Count), 1);
    wait_drain(200);
    exp_l = '{8'h5A, 8'h5B};
    chk_emitted("t4_emit", exp_l);

    // Overflow while transmitter is held
    dn_dly = 1; dn_len = 2; dn_hold = 1;
    emit_q.delete();
    write_byte(8'h60);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      write_byte(8'h60 + 8'(i));
      if (i == 8) begin
        chk("t5_count_8", int'(o_Count), 8);
        chk("t5_ovf_8",   int'(o_Overflow), 0);
      end
      if (i == 9)  chk("t5_ovf_9",    int'(o_Overflow), 1);
      if (i == 10) chk("t5_count_10", int'(o_Count), 8);
    end
    dn_hold = 0;
    wait_drain(2000);
    chk("t5_ovf_sticky", int'(o_Overflow), 1);
    exp_l = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    chk_emitted("t5_emit", exp_l);

    // Asynchronous reset in WAIT_DONE with three bytes queued
    dn_dly = 1; dn_len = 30;
    write_byte(8'h70);
    guard = 0;
    while (!(ref_holding && ref_acked) && guard < 50) begin
      @(negedge clk); guard++;
    end
    write_byte(8'h71);
    write_byte(8'h72);
    write_byte(8'h73);
    chk("t6_count_pre", int'(o_Count), 3);
    chk("t6_in_wait",   int'(ref_holding && ref_acked && o_Busy && !o_Tx_DV), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_count_imm", int'(o_Count), 0);
    chk("t6_empty_imm", int'(o_Empty), 1);
    chk("t6_full_imm",  int'(o_Full), 0);
    chk("t6_ovf_imm",   int'(o_Overflow), 0);
    chk("t6_dv_imm",    int'(o_Tx_DV), 0);
    chk("t6_byte_imm",  int'(o_Tx_Byte), 0);
    chk("t6_busy_imm",  int'(o_Busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_dv", int'(o_Tx_DV), 0);
    end

    // Randomized traffic
    dn_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) wr_dv = ($urandom_range(0, 1) == 0);
      else          wr_dv = ($urandom_range(0, 5) == 0);
      wr_byte = 8'($urandom);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    wait_drain(3000);
    chk("t7_sb_empty", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
